// File: rtl/sdram_fill_bridge_pkg.sv
// Shared constants for the cache-to-SDRAM fill bridge: FSM encodings, command codes
// and the read-beat lane replication helper.
package sdram_fill_bridge_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_RDATA = 3'd2;
  localparam logic [2:0] ST_WDONE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ  = 1'b1;

  // Caches write byte lanes of a 32-bit word, so each halfword is presented on both halves.
  function automatic logic [31:0] hw_replicate(input logic [15:0] hw);
    return {hw, hw};
  endfunction

endpackage

// File: rtl/sdram_fill_bridge_rr_arbiter2.sv
// Two-requester round-robin arbiter; bit 0 is the I-port, bit 1 the D-port.
// A tie goes to the requester that did not win last; reset leaves D as last winner.
module rr_arbiter2 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_d ? 2'b01 : 2'b10;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      last_d <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_d <= gnt[1];
    end
  end

endmodule

// File: rtl/sdram_fill_bridge.sv
// Cache fill bridge: arbitrates ICache/DCache, issues BL-beat read bursts or single
// halfword writes to the SDRAM controller and returns beats replicated on 32 bits.
module sdram_fill_bridge
  import sdram_fill_bridge_pkg::*;
#(
  parameter  int BL     = 4,
  parameter  int AW     = 22,
  parameter  int TO_CYC = 255,
  localparam int BW     = $clog2(BL)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          IStrobe,
  input  logic          IRW,
  input  logic [31:0]   IAddress,
  output logic          IGrant,
  output logic          IRValid,
  output logic [BW-1:0] IBeat,
  output logic [31:0]   IRData,
  output logic          IDone,
  output logic          IErr,
  input  logic          DStrobe,
  input  logic          DRW,
  input  logic [31:0]   DAddress,
  input  logic [15:0]   DWData,
  output logic          DGrant,
  output logic          DRValid,
  output logic [BW-1:0] DBeat,
  output logic [31:0]   DRData,
  output logic          DDone,
  output logic          DErr,
  output logic          sdrReq,
  output logic          sdrRW,
  output logic [AW-1:0] sdrAddr,
  output logic [15:0]   sdrWData,
  input  logic          sdrAck,
  input  logic          sdrRValid,
  input  logic [15:0]   sdrRData
);

  localparam int TW = $clog2(TO_CYC + 1);

  logic [2:0]    state;
  logic          cur_d;
  logic          grant_r;
  logic          done_r;
  logic          err_r;
  logic          lat_rw;
  logic [AW-1:0] lat_addr;
  logic [15:0]   lat_wdata;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          arb_adv;
  logic [1:0]    arb_gnt;
  logic          vld_p1;
  logic [31:0]   rdata_p1;
  logic [BW-1:0] beat_p1;
  logic          unused_ok;

  // The I-cache never writes, and only AW address bits reach the SDRAM.
  assign unused_ok = ^{IRW, IAddress[31:AW], DAddress[31:AW]};

  assign arb_adv = (state == ST_IDLE) && (IStrobe || DStrobe);
  assign to_hit  = (to_cnt == TW'(TO_CYC - 1));

  rr_arbiter2 u_arb (
    .Clk     (Clk),
    .Reset   (Reset),
    .req     ({DStrobe, IStrobe}),
    .advance (arb_adv),
    .gnt     (arb_gnt)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      cur_d     <= 1'b0;
      grant_r   <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      beat_cnt  <= '0;
      to_cnt    <= '0;
      vld_p1    <= 1'b0;
      rdata_p1  <= '0;
      beat_p1   <= '0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_adv) begin
            cur_d     <= arb_gnt[1];
            lat_rw    <= arb_gnt[1] ? DRW : CMD_READ;
            lat_addr  <= arb_gnt[1] ? DAddress[AW-1:0] : IAddress[AW-1:0];
            lat_wdata <= arb_gnt[1] ? DWData : lat_wdata;
            grant_r   <= 1'b1;
            err_r     <= 1'b0;
            beat_cnt  <= '0;
            to_cnt    <= '0;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sdrAck) begin
            to_cnt <= '0;
            state  <= (lat_rw == CMD_READ) ? ST_RDATA : ST_WDONE;
          end else if (to_hit) begin
            err_r  <= 1'b1;
            done_r <= 1'b1;
            state  <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        ST_RDATA: begin
          // Stage p1: one-cycle registered forward of each controller beat.
          if (sdrRValid) begin
            vld_p1   <= 1'b1;
            rdata_p1 <= hw_replicate(sdrRData);
            beat_p1  <= beat_cnt;
            beat_cnt <= beat_cnt + BW'(1);
            to_cnt   <= '0;
            if (beat_cnt == BW'(BL - 1)) begin
              done_r <= 1'b1;
              state  <= ST_DONE;
            end
          end else if (to_hit) begin
            err_r  <= 1'b1;
            done_r <= 1'b1;
            state  <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        ST_WDONE: begin
          done_r <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done_r   <= 1'b0;
          err_r    <= 1'b0;
          grant_r  <= 1'b0;
          rdata_p1 <= '0;
          beat_p1  <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sdrReq   = (state == ST_REQ);
  assign sdrRW    = lat_rw;
  assign sdrAddr  = lat_addr;
  assign sdrWData = lat_wdata;

  // Registered status is steered to the owning port; the other port stays at 0.
  assign IGrant  = grant_r & ~cur_d;
  assign IRValid = vld_p1 & ~cur_d;
  assign IRData  = cur_d ? '0 : rdata_p1;
  assign IBeat   = cur_d ? '0 : beat_p1;
  assign IDone   = done_r & ~cur_d;
  assign IErr    = err_r & ~cur_d;

  assign DGrant  = grant_r & cur_d;
  assign DRValid = vld_p1 & cur_d;
  assign DRData  = cur_d ? rdata_p1 : '0;
  assign DBeat   = cur_d ? beat_p1 : '0;
  assign DDone   = done_r & cur_d;
  assign DErr    = err_r & cur_d;

endmodule
